// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed scan controller for an N_DIGITS-wide 7-segment display.
// Display data arrives through a valid/ready load port into shadow registers.
// It is copied into the active registers only at a frame boundary, so a frame
// never mixes old and new data. Each digit slot starts with BLANK_CYCLES of
// all-anodes-off to suppress ghosting.
//
// Optional feature (macro SEG7_LEADING_ZERO_BLANK_EN): enabled digits above
// the most significant enabled nonzero nibble are suppressed. Digit 0 is
// always shown when it is enabled.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   load_valid   in   new display data offered
//   load_ready   out  controller can accept data
//   load_value   in   [31:0] hex nibbles, digit i = load_value[4i+3:4i]
//   load_en_mask in   [7:0] digit i shown when bit i = 1
//   load_dp_mask in   [7:0] decimal point i lit when bit i = 1
//   seg          out  [6:0] active-low segments, seg[0]=a .. seg[6]=g
//   an           out  [7:0] active-low anodes, an[i] selects digit i
//   dp           out  active-low decimal point
//   frame_start  out  one-cycle pulse when the digit 0 slot begins
//   dbg_state_o  out  scan FSM state (0 = BLANK, 1 = DRIVE)
//
// Handshake: a transfer happens on a rising edge where load_valid and
// load_ready are both 1. load_ready stays low while a transfer is waiting for
// the next frame boundary, and load_valid is ignored during that time.
module seg7_scan_ctrl #(
  parameter int N_DIGITS     = 8,
  parameter int TICK_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_value,
  input  logic [7:0]  load_en_mask,
  input  logic [7:0]  load_dp_mask,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        dp,
  output logic        frame_start,
  output logic        dbg_state_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_DRIVE = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DRIVE_AT = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             state_q, state_d;
  logic             pending_q, pending_d;
  logic [31:0]      shadow_value_q, shadow_value_d;
  logic [7:0]       shadow_en_q, shadow_en_d;
  logic [7:0]       shadow_dp_q, shadow_dp_d;
  logic [31:0]      act_value_q, act_value_d;
  logic [7:0]       act_en_q, act_en_d;
  logic [7:0]       act_dp_q, act_dp_d;
  logic [6:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;
  logic             dp_q, dp_d;
  logic             frame_start_q, frame_start_d;

  logic       slot_end;
  logic       boundary;
  logic       load_fire;
  logic [3:0] nibble;
  logic       lz_ok;
  logic       drive_next;

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign slot_end  = (cnt_q == CNT_LAST);
  assign boundary  = slot_end && (idx_q == IDX_LAST);
  // load_ready is simply the inverse of the pending flag, itself a register.
  assign load_fire = load_valid && !pending_q;
  assign nibble    = act_value_q[{idx_q, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] lead_k;

  // Highest enabled digit holding a nonzero nibble; 0 when none qualifies.
  always_comb begin
    lead_k = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (act_en_q[i] && (act_value_q[4*i +: 4] != 4'h0)) lead_k = IDX_W'(i);
    end
  end

  assign lz_ok = (idx_q <= lead_k);
`else
  assign lz_ok = 1'b1;
`endif

  always_comb begin
    cnt_d          = slot_end ? '0 : cnt_q + 1'b1;
    idx_d          = idx_q;
    state_d        = state_q;
    pending_d      = pending_q;
    shadow_value_d = shadow_value_q;
    shadow_en_d    = shadow_en_q;
    shadow_dp_d    = shadow_dp_q;
    act_value_d    = act_value_q;
    act_en_d       = act_en_q;
    act_dp_d       = act_dp_q;
    frame_start_d  = boundary;

    if (slot_end) begin
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      state_d = ST_BLANK;
    end else if (cnt_q == CNT_DRIVE_AT) begin
      state_d = ST_DRIVE;
    end

    // Commit at the boundary uses the pending flag sampled before this edge,
    // so data accepted on the boundary edge itself waits a full frame.
    if (boundary && pending_q) begin
      act_value_d = shadow_value_q;
      act_en_d    = shadow_en_q;
      act_dp_d    = shadow_dp_q;
      pending_d   = 1'b0;
    end

    if (load_fire) begin
      shadow_value_d = load_value;
      shadow_en_d    = load_en_mask;
      shadow_dp_d    = load_dp_mask;
      pending_d      = 1'b1;
    end

    // Outputs are registered: they follow the state being entered this edge.
    drive_next = (state_d == ST_DRIVE) && act_en_q[idx_q] && lz_ok;
    seg_d      = drive_next ? hex_decode(nibble) : 7'h7F;
    an_d       = drive_next ? ~(8'b1 << idx_q) : 8'hFF;
    dp_d       = drive_next ? ~act_dp_q[idx_q] : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      state_q        <= ST_BLANK;
      pending_q      <= 1'b0;
      shadow_value_q <= '0;
      shadow_en_q    <= 8'hFF;
      shadow_dp_q    <= 8'h00;
      act_value_q    <= '0;
      act_en_q       <= 8'hFF;
      act_dp_q       <= 8'h00;
      seg_q          <= 7'h7F;
      an_q           <= 8'hFF;
      dp_q           <= 1'b1;
      frame_start_q  <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      state_q        <= state_d;
      pending_q      <= pending_d;
      shadow_value_q <= shadow_value_d;
      shadow_en_q    <= shadow_en_d;
      shadow_dp_q    <= shadow_dp_d;
      act_value_q    <= act_value_d;
      act_en_q       <= act_en_d;
      act_dp_q       <= act_dp_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
      dp_q           <= dp_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign load_ready  = ~pending_q;
  assign seg         = seg_q;
  assign an          = an_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with TICK_DIV=8, BLANK_CYCLES=2,
// N_DIGITS=8: one slot is 8 cycles, one frame is 64 cycles.
// cyc counts rising edges since the last reset release; outputs are sampled
// on the falling edge that follows, so at cyc the slot is cyc/8 % 8 and the
// slot counter is cyc % 8.
module tb_seg7_scan_ctrl;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_value;
  logic [7:0]  load_en_mask;
  logic [7:0]  load_dp_mask;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        dp;
  logic        frame_start;
  logic        dbg_state;

  int cyc;
  int checks;
  int errors;

  // Hand-written segment codes (gfedcba, active-low).
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;

  seg7_scan_ctrl #(
    .N_DIGITS    (8),
    .TICK_DIV    (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .load_en_mask(load_en_mask),
    .load_dp_mask(load_dp_mask),
    .seg         (seg),
    .an          (an),
    .dp          (dp),
    .frame_start (frame_start),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver / checker tasks
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Checks one driven-or-suppressed digit sample.
  task automatic check_digit(input string tag, input int d, input bit shown,
                             input logic [6:0] s, input logic dpv);
    logic [7:0] one;
    one = 8'b1 << d;
    check({tag, ".an"},  {24'h0, an},   shown ? {24'h0, ~one} : 32'hFF);
    check({tag, ".seg"}, {25'h0, seg},  shown ? {25'h0, s} : 32'h7F);
    check({tag, ".dp"},  {31'h0, dp},   shown ? {31'h0, dpv} : 32'h1);
  endtask

  task automatic offer(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dpm);
    load_valid   = 1'b1;
    load_value   = v;
    load_en_mask = en;
    load_dp_mask = dpm;
  endtask

  initial begin
    logic [7:0] exp_an;
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    rst          = 1'b1;
    load_valid   = 1'b0;
    load_value   = '0;
    load_en_mask = '0;
    load_dp_mask = '0;

    // Reset values
    #1;
    check("rst.seg",   {25'h0, seg},         32'h7F);
    check("rst.an",    {24'h0, an},          32'hFF);
    check("rst.dp",    {31'h0, dp},          32'h1);
    check("rst.ready", {31'h0, load_ready},  32'h1);
    check("rst.fs",    {31'h0, frame_start}, 32'h0);
    check("rst.state", {31'h0, dbg_state},   32'h0);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    // First drive after reset: digit 0 showing 0
    run_to(1);
    check("boot.blank.an", {24'h0, an}, 32'hFF);
    run_to(2);
    check_digit("boot.d0", 0, 1'b1, S0, 1'b1);
    check("boot.state", {31'h0, dbg_state}, 32'h1);

    // Reset asserted mid-DRIVE takes effect immediately
    run_to(4);
    rst = 1'b1;
    #1;
    check("midrst.an",    {24'h0, an},         32'hFF);
    check("midrst.seg",   {25'h0, seg},        32'h7F);
    check("midrst.dp",    {31'h0, dp},         32'h1);
    check("midrst.ready", {31'h0, load_ready}, 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    run_to(2);
    check_digit("rel.d0", 0, 1'b1, S0, 1'b1);

    // Slot timing: 2 blank cycles then 6 driven cycles; frame_start every 64
    while (cyc < 70) begin
      tick();
      exp_an = 8'hFF;
      if ((cyc % 8) >= 2 && !(LZ && ((cyc / 8) % 8) != 0))
        exp_an = ~(8'b1 << ((cyc / 8) % 8));
      check("slot.an", {24'h0, an}, {24'h0, exp_an});
      check("slot.fs", {31'h0, frame_start}, {31'h0, (cyc % 64) == 0});
    end

    // Mid-frame load: value 00007F39, en FF, dp 02
    offer(32'h00007F39, 8'hFF, 8'h02);
    tick();
    load_valid = 1'b0;
    check("ld1.ready_drop", {31'h0, load_ready}, 32'h0);
    run_to(122);
    check_digit("ld1.old.d7", 7, !LZ, S0, 1'b1);
    run_to(127);
    check("ld1.ready_pre", {31'h0, load_ready}, 32'h0);
    check("ld1.fs_pre", {31'h0, frame_start}, 32'h0);
    run_to(128);
    check("ld1.fs", {31'h0, frame_start}, 32'h1);
    check("ld1.ready_back", {31'h0, load_ready}, 32'h1);
    run_to(129);
    check("ld1.fs_width", {31'h0, frame_start}, 32'h0);
    run_to(130);
    check_digit("ld1.d0", 0, 1'b1, S9, 1'b1);
    run_to(138);
    check_digit("ld1.d1", 1, 1'b1, S3, 1'b0);
    run_to(146);
    check_digit("ld1.d2", 2, 1'b1, SF, 1'b1);
    run_to(154);
    check_digit("ld1.d3", 3, 1'b1, S7, 1'b1);
    run_to(162);
    check_digit("ld1.d4", 4, !LZ, S0, 1'b1);

    // Load 76543210 with en F5, then hold a second offer while pending
    run_to(170);
    offer(32'h76543210, 8'hF5, 8'h00);
    tick();
    check("ld2.ready_drop", {31'h0, load_ready}, 32'h0);
    offer(32'hFFFFFFFF, 8'hFF, 8'hFF);
    run_to(186);
    check_digit("ld1.d7", 7, !LZ, S0, 1'b1);
    run_to(191);
    check("ld3.blocked", {31'h0, load_ready}, 32'h0);
    run_to(192);
    check("ld2.fs", {31'h0, frame_start}, 32'h1);
    check("ld2.ready_back", {31'h0, load_ready}, 32'h1);
    run_to(193);
    load_valid = 1'b0;
    check("ld3.accepted", {31'h0, load_ready}, 32'h0);

    // Frame with en F5: slots 1 and 3 stay dark for all 8 cycles
    run_to(194);
    check_digit("f5.d0", 0, 1'b1, S0, 1'b1);
    while (cyc < 207) begin
      tick();
      if (cyc >= 200) check("f5.slot1.an", {24'h0, an}, 32'hFF);
    end
    run_to(210);
    check_digit("f5.d2", 2, 1'b1, S2, 1'b1);
    while (cyc < 223) begin
      tick();
      if (cyc >= 216) check("f5.slot3.an", {24'h0, an}, 32'hFF);
    end
    run_to(226);
    check_digit("f5.d4", 4, 1'b1, S4, 1'b1);

    // Held offer (accepted at 193) applies at 256
    run_to(256);
    check("ld3.fs", {31'h0, frame_start}, 32'h1);
    check("ld3.ready_back", {31'h0, load_ready}, 32'h1);
    run_to(258);
    check_digit("ld3.d0", 0, 1'b1, SF, 1'b0);

    // Offer accepted exactly on the boundary edge at 320 waits until 384
    run_to(319);
    offer(32'h000000A5, 8'hFF, 8'h00);
    tick();
    load_valid = 1'b0;
    check("ld4.fs", {31'h0, frame_start}, 32'h1);
    check("ld4.ready_drop", {31'h0, load_ready}, 32'h0);
    run_to(322);
    check_digit("ld4.old.d0", 0, 1'b1, SF, 1'b0);
    run_to(383);
    check("ld4.ready_pre", {31'h0, load_ready}, 32'h0);
    run_to(384);
    check("ld4.ready_back", {31'h0, load_ready}, 32'h1);
    run_to(386);
    check_digit("ld4.d0", 0, 1'b1, S5, 1'b1);
    run_to(394);
    check_digit("ld4.d1", 1, 1'b1, SA, 1'b1);
    run_to(402);
    check_digit("ld4.d2", 2, !LZ, S0, 1'b1);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
